// File: rtl/note_pkg.sv
// Shared types and constants for the note highway renderer.
// Colours, screen geometry, slot and pipeline bundles.
package note_pkg;

  localparam int LANES    = 4;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = '{4'h0, 4'h0, 4'h0};
  localparam rgb_t COL_WHITE  = '{4'hF, 4'hF, 4'hF};
  localparam rgb_t COL_GREY   = '{4'h2, 4'h2, 4'h2};
  localparam rgb_t COL_GREEN  = '{4'h0, 4'hF, 4'h0};
  localparam rgb_t COL_RED    = '{4'hF, 4'h0, 4'h0};
  localparam rgb_t COL_YELLOW = '{4'hF, 4'hF, 4'h0};
  localparam rgb_t COL_BLUE   = '{4'h0, 4'h0, 4'hF};

  typedef struct packed {
    logic       active;
    logic [9:0] y;
  } slot_t;

  typedef struct packed {
    logic       vis;
    logic       in_lane;
    logic       xok;
    logic [1:0] lane;
    logic [9:0] vc;
  } render_s1_t;

  function automatic rgb_t lane_colour(input logic [1:0] l);
    rgb_t c;
    c = COL_BLACK;
    unique case (l)
      2'd0: c = COL_GREEN;
      2'd1: c = COL_RED;
      2'd2: c = COL_YELLOW;
      2'd3: c = COL_BLUE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/note_lane.sv
// One lane of falling notes: spawn, scroll, hit/miss judgement
// and the per-row occupancy query used by the renderer.
module note_lane
  import note_pkg::*;
#(
  parameter int SLOTS   = 8,
  parameter int NOTE_H  = 16,
  parameter int SPEED   = 4,
  parameter int HIT_Y   = 432,
  parameter int HIT_WIN = 12
) (
  input  logic       vgaclk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       hit_btn,
  input  logic [9:0] qy,
  output logic       has_free,
  output logic       row_hit,
  output logic       hit_ok,
  output logic       hit_bad,
  output logic       miss
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  slot_t            slots [SLOTS];
  logic [10:0]      ny    [SLOTS];
  logic [10:0]      ctr   [SLOTS];
  logic [SLOTS-1:0] gone;
  logic [SLOTS-1:0] drop;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    cand_idx;
  logic             has_cand;
  logic             any_miss;

  // Slot search: lowest free slot, lowest hit candidate, row match.
  always_comb begin
    ny       = '{default: '0};
    ctr      = '{default: '0};
    gone     = '0;
    drop     = '0;
    free_idx = '0;
    cand_idx = '0;
    has_free = 1'b0;
    has_cand = 1'b0;
    row_hit  = 1'b0;
    any_miss = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      ny[i]  = {1'b0, slots[i].y} + 11'(SPEED);
      ctr[i] = {1'b0, slots[i].y} + 11'(NOTE_H / 2);
      if (!slots[i].active) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
      if (slots[i].active &&
          ctr[i] >= 11'(HIT_Y - HIT_WIN) &&
          ctr[i] <= 11'(HIT_Y + HIT_WIN)) begin
        has_cand = 1'b1;
        cand_idx = IW'(i);
      end
      if (slots[i].active &&
          {1'b0, qy} >= {1'b0, slots[i].y} &&
          {1'b0, qy} < {1'b0, slots[i].y} + 11'(NOTE_H))
        row_hit = 1'b1;
    end
    for (int i = 0; i < SLOTS; i++) begin
      gone[i] = hit_btn && has_cand && (cand_idx == IW'(i));
      drop[i] = frame_tick && slots[i].active && !gone[i] &&
                (ny[i] >= 11'(SCREEN_H));
      any_miss = any_miss | drop[i];
    end
  end

  // Slot state and one-cycle judgement pulses.
  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
      hit_ok  <= 1'b0;
      hit_bad <= 1'b0;
      miss    <= 1'b0;
    end else begin
      hit_ok  <= hit_btn && has_cand;
      hit_bad <= hit_btn && !has_cand;
      miss    <= any_miss;
      for (int i = 0; i < SLOTS; i++) begin
        if (gone[i] || drop[i])
          slots[i].active <= 1'b0;
        else if (frame_tick && slots[i].active)
          slots[i].y <= ny[i][9:0];
        else if (spawn && has_free && free_idx == IW'(i))
          slots[i] <= '{active: 1'b1, y: 10'd0};
      end
    end
  end

endmodule

// File: rtl/note_highway_render.sv
// Four-lane note highway pixel source with a two-stage
// colour pipeline feeding the VGA output block.
module note_highway_render
  import note_pkg::*;
#(
  parameter int SLOTS       = 8,
  parameter int LANE_X0     = 192,
  parameter int LANE_W      = 64,
  parameter int NOTE_MARGIN = 4,
  parameter int NOTE_H      = 16,
  parameter int SPEED       = 4,
  parameter int HIT_Y       = 432,
  parameter int HIT_WIN     = 12
) (
  input  logic       vgaclk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       frame_tick,
  input  logic       spawn_valid,
  input  logic [1:0] spawn_lane,
  output logic       spawn_ready,
  input  logic [3:0] hit_btn,
  output logic [3:0] hit_ok,
  output logic [3:0] hit_bad,
  output logic [3:0] miss,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  logic [LANES-1:0] free;
  logic [LANES-1:0] row_hit;
  logic [LANES-1:0] spawn_go;
  render_s1_t       s1_d;
  render_s1_t       s1_q;
  rgb_t             px;
  logic [9:0]       rel;
  logic [9:0]       off;

  assign spawn_ready = !frame_tick && free[spawn_lane];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign spawn_go[g] = spawn_valid && spawn_ready &&
                         (spawn_lane == 2'(g));
    note_lane #(
      .SLOTS   (SLOTS),
      .NOTE_H  (NOTE_H),
      .SPEED   (SPEED),
      .HIT_Y   (HIT_Y),
      .HIT_WIN (HIT_WIN)
    ) u_lane (
      .vgaclk     (vgaclk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .spawn      (spawn_go[g]),
      .hit_btn    (hit_btn[g]),
      .qy         (s1_q.vc),
      .has_free   (free[g]),
      .row_hit    (row_hit[g]),
      .hit_ok     (hit_ok[g]),
      .hit_bad    (hit_bad[g]),
      .miss       (miss[g])
    );
  end

  // S1 decode: lane membership, lane index and note inset.
  always_comb begin
    rel          = hc - 10'(LANE_X0);
    off          = rel % 10'(LANE_W);
    s1_d         = '0;
    s1_d.vc      = vc;
    s1_d.vis     = (hc < 10'(SCREEN_W)) && (vc < 10'(SCREEN_H));
    s1_d.in_lane = (hc >= 10'(LANE_X0)) &&
                   (hc < 10'(LANE_X0 + LANES * LANE_W));
    s1_d.lane    = 2'(rel / 10'(LANE_W));
    s1_d.xok     = s1_d.in_lane &&
                   (off >= 10'(NOTE_MARGIN)) &&
                   (off < 10'(LANE_W - NOTE_MARGIN));
  end

  // S1 register stage.
  always_ff @(posedge vgaclk) begin
    if (!rst) s1_q <= '0;
    else      s1_q <= s1_d;
  end

  // S2 colour priority: blank, note, hit line, lane, background.
  always_comb begin
    px = COL_BLACK;
    priority case (1'b1)
      !s1_q.vis:
        px = COL_BLACK;
      row_hit[s1_q.lane] && s1_q.xok:
        px = lane_colour(s1_q.lane);
      s1_q.in_lane && (s1_q.vc == 10'(HIT_Y) ||
                       s1_q.vc == 10'(HIT_Y + 1)):
        px = COL_WHITE;
      s1_q.in_lane:
        px = COL_GREY;
      default:
        px = COL_BLACK;
    endcase
  end

  // S2 register stage drives the pixel outputs.
  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else begin
      red   <= px.r;
      green <= px.g;
      blue  <= px.b;
    end
  end

endmodule

// File: tb/tb_note_highway_render.sv
// Directed bench for note_highway_render with a pixel
// scoreboard matching the two-cycle colour latency.
module tb_note_highway_render;

  localparam logic [11:0] BLK = 12'h000;
  localparam logic [11:0] WHT = 12'hFFF;
  localparam logic [11:0] GRY = 12'h222;
  localparam logic [11:0] GRN = 12'h0F0;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] YEL = 12'hFF0;
  localparam logic [11:0] BLU = 12'h00F;

  logic       vgaclk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hc = '0;
  logic [9:0] vc = '0;
  logic       frame_tick = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [1:0] spawn_lane = '0;
  logic       spawn_ready;
  logic [3:0] hit_btn = '0;
  logic [3:0] hit_ok;
  logic [3:0] hit_bad;
  logic [3:0] miss;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  typedef struct {
    bit          v;
    logic [11:0] rgb;
    int          h;
    int          vv;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  int         n_assert = 0;
  int         n_fail = 0;
  int         miss_pulses = 0;
  logic [3:0] last_miss = '0;

  note_highway_render dut (
    .vgaclk      (vgaclk),
    .rst         (rst),
    .hc          (hc),
    .vc          (vc),
    .frame_tick  (frame_tick),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .hit_btn     (hit_btn),
    .hit_ok      (hit_ok),
    .hit_bad     (hit_bad),
    .miss        (miss),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk();
    exp_t e;
    q.push_back(cur);
    cur.v = 1'b0;
    @(posedge vgaclk);
    #1;
    if (miss != 4'h0) miss_pulses++;
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (e.v)
        chk($sformatf("pix(%0d,%0d)", e.h, e.vv),
            {20'h0, red, green, blue}, {20'h0, e.rgb});
    end
  endtask

  task automatic px(input int h, input int v, input logic [11:0] c);
    hc  = 10'(h);
    vc  = 10'(v);
    cur = '{v: 1'b1, rgb: c, h: h, vv: v};
    clk();
  endtask

  task automatic flush();
    hc = 10'd799;
    vc = 10'd524;
    clk();
    clk();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " hit_ok"}, {28'h0, hit_ok}, 32'h0);
    chk({tag, " hit_bad"}, {28'h0, hit_bad}, 32'h0);
    chk({tag, " miss"}, {28'h0, miss}, 32'h0);
  endtask

  task automatic do_reset();
    flush();
    rst = 1'b0;
    clk();
    clk();
    chk("rst rgb", {20'h0, red, green, blue}, 32'h0);
    chk_quiet("rst");
    rst = 1'b1;
    clk();
    miss_pulses = 0;
  endtask

  task automatic tick1();
    frame_tick = 1'b1;
    clk();
    frame_tick = 1'b0;
    last_miss = miss;
    clk();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick1();
  endtask

  task automatic spawn(input logic [1:0] l);
    spawn_valid = 1'b1;
    spawn_lane  = l;
    clk();
    spawn_valid = 1'b0;
  endtask

  task automatic hit(input logic [3:0] m, input logic [3:0] ok,
                     input logic [3:0] bad, input string tag);
    hit_btn = m;
    clk();
    hit_btn = 4'h0;
    chk({tag, " hit_ok"}, {28'h0, hit_ok}, {28'h0, ok});
    chk({tag, " hit_bad"}, {28'h0, hit_bad}, {28'h0, bad});
  endtask

  function automatic logic [11:0] bg(input int h, input int v);
    if (h >= 640 || v >= 480) return BLK;
    if (h < 192 || h >= 448) return BLK;
    if (v == 432 || v == 433) return WHT;
    return GRY;
  endfunction

  initial begin
    int rows [10];
    int cols [10];
    cur.v = 1'b0;
    rows = '{0, 1, 240, 431, 432, 433, 434, 479, 480, 524};
    cols = '{0, 191, 192, 193, 446, 447, 448, 639, 640, 799};

    // empty highway background
    do_reset();
    foreach (rows[r])
      for (int h = 0; h < 800; h++) px(h, rows[r], bg(h, rows[r]));
    foreach (cols[c])
      for (int v = 0; v < 525; v++) px(cols[c], v, bg(cols[c], v));
    flush();
    chk("bg miss", miss_pulses, 0);
    chk_quiet("bg");

    // spawn, scroll one step, lane colour and margins
    do_reset();
    spawn_valid = 1'b1;
    spawn_lane  = 2'd2;
    #1;
    chk("ready l2", {31'h0, spawn_ready}, 32'h1);
    clk();
    spawn_valid = 1'b0;
    tick1();
    px(328, 10, YEL);
    px(322, 10, GRY);
    px(323, 10, GRY);
    px(324, 10, YEL);
    px(379, 10, YEL);
    px(380, 10, GRY);
    px(328, 3, GRY);
    px(328, 4, YEL);
    px(328, 19, YEL);
    px(328, 20, GRY);
    flush();

    // full lane, blocked spawn during frame_tick
    do_reset();
    spawn_valid = 1'b1;
    spawn_lane  = 2'd1;
    frame_tick  = 1'b1;
    #1;
    chk("ready tick", {31'h0, spawn_ready}, 32'h0);
    clk();
    frame_tick  = 1'b0;
    spawn_valid = 1'b0;
    px(288, 0, GRY);
    flush();
    for (int k = 0; k < 8; k++) begin
      spawn_valid = 1'b1;
      spawn_lane  = 2'd0;
      #1;
      chk($sformatf("ready l0 #%0d", k), {31'h0, spawn_ready}, 32'h1);
      clk();
    end
    #1;
    chk("ready l0 full", {31'h0, spawn_ready}, 32'h0);
    spawn_lane = 2'd1;
    #1;
    chk("ready l1 free", {31'h0, spawn_ready}, 32'h1);
    spawn_lane = 2'd0;
    clk();
    spawn_valid = 1'b0;
    px(224, 5, GRN);
    px(288, 5, GRY);
    flush();
    ticks(106);
    for (int k = 0; k < 8; k++)
      hit(4'h1, 4'h1, 4'h0, $sformatf("full hit%0d", k));
    hit(4'h1, 4'h0, 4'h1, "ninth");
    chk("full miss", miss_pulses, 0);

    // note leaves screen unhit
    do_reset();
    spawn(2'd1);
    ticks(119);
    chk("pre miss", miss_pulses, 0);
    px(288, 478, RED);
    flush();
    frame_tick = 1'b1;
    clk();
    frame_tick = 1'b0;
    chk("miss pulse", {28'h0, miss}, 32'h2);
    clk();
    chk("miss clear", {28'h0, miss}, 32'h0);
    chk("miss once", miss_pulses, 1);
    px(288, 478, GRY);
    flush();
    spawn(2'd1);
    px(288, 5, RED);
    flush();

    // hit window edges and repeat strum
    do_reset();
    spawn(2'd3);
    ticks(102);
    px(416, 412, BLU);
    flush();
    hit(4'h8, 4'h0, 4'h8, "y408");
    tick1();
    hit(4'h8, 4'h8, 4'h0, "y412");
    px(416, 415, GRY);
    flush();
    hit(4'h8, 4'h0, 4'h8, "empty3");
    spawn(2'd3);
    ticks(106);
    px(416, 430, BLU);
    flush();
    hit(4'h8, 4'h8, 4'h0, "y424");
    px(416, 430, GRY);
    flush();
    hit(4'h8, 4'h0, 4'h8, "again3");
    spawn(2'd3);
    ticks(109);
    hit(4'h8, 4'h8, 4'h0, "y436");
    spawn(2'd3);
    ticks(110);
    hit(4'h8, 4'h0, 4'h8, "y440");

    // hit coincident with frame_tick, other note misses
    do_reset();
    spawn(2'd0);
    ticks(13);
    spawn(2'd0);
    ticks(106);
    hit_btn    = 4'h1;
    frame_tick = 1'b1;
    clk();
    hit_btn    = 4'h0;
    frame_tick = 1'b0;
    chk("co hit_ok", {28'h0, hit_ok}, 32'h1);
    chk("co miss", {28'h0, miss}, 32'h1);
    clk();
    tick1();
    chk("co after", {28'h0, last_miss}, 32'h0);
    chk("co misses", miss_pulses, 1);
    hit(4'h1, 4'h0, 4'h1, "co empty");

    // reset mid-frame discards notes silently
    do_reset();
    for (int l = 0; l < 4; l++) spawn(2'(l));
    ticks(119);
    px(224, 478, GRN);
    px(416, 478, BLU);
    flush();
    rst = 1'b0;
    clk();
    chk("mid rgb", {20'h0, red, green, blue}, 32'h0);
    chk_quiet("mid");
    rst = 1'b1;
    clk();
    px(224, 478, GRY);
    px(416, 478, GRY);
    flush();
    tick1();
    chk("mid tick", {28'h0, last_miss}, 32'h0);
    chk("mid misses", miss_pulses, 0);
    hit(4'hF, 4'h0, 4'hF, "mid empty");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
